// File: rtl/lm80c_kbd_pkg.sv
// Shared constants, receiver state type and the PS/2 set-2 to LM80C matrix map.
// key_map() is the single place that decides which matrix cell a scan code drives.
package lm80c_kbd_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;

  // Keyboard housekeeping bytes (BAT ok, echo, ack, resend, errors) that never map to keys.
  localparam logic [5:0][7:0] PS2_IGNORE = {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  function automatic logic is_ignored(input logic [7:0] code);
    logic r;
    r = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (code == PS2_IGNORE[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic key_pos_t kp(input logic [2:0] row, input logic [2:0] col);
    key_pos_t k;
    k.hit = 1'b1;
    k.row = row;
    k.col = col;
    return k;
  endfunction

  // Index is {ext, code}; cursor keys other than Up share the cursor-down cell.
  function automatic key_pos_t key_map(input logic ext, input logic [7:0] code);
    key_pos_t k;
    k = '0;
    case ({ext, code})
      9'h016: k = kp(3'd0, 3'd0);  9'h01E: k = kp(3'd0, 3'd1);
      9'h026: k = kp(3'd0, 3'd2);  9'h175: k = kp(3'd0, 3'd3);
      9'h025: k = kp(3'd0, 3'd4);  9'h02E: k = kp(3'd0, 3'd5);
      9'h036: k = kp(3'd0, 3'd6);  9'h03D: k = kp(3'd0, 3'd7);
      9'h015: k = kp(3'd1, 3'd0);  9'h01D: k = kp(3'd1, 3'd1);
      9'h01C: k = kp(3'd1, 3'd2);  9'h01B: k = kp(3'd1, 3'd3);
      9'h01A: k = kp(3'd1, 3'd4);  9'h024: k = kp(3'd1, 3'd5);
      9'h023: k = kp(3'd1, 3'd6);  9'h022: k = kp(3'd1, 3'd7);
      9'h02D: k = kp(3'd2, 3'd0);  9'h02B: k = kp(3'd2, 3'd1);
      9'h021: k = kp(3'd2, 3'd2);  9'h02C: k = kp(3'd2, 3'd3);
      9'h034: k = kp(3'd2, 3'd4);  9'h02A: k = kp(3'd2, 3'd5);
      9'h035: k = kp(3'd2, 3'd6);  9'h033: k = kp(3'd2, 3'd7);
      9'h032: k = kp(3'd3, 3'd0);  9'h03C: k = kp(3'd3, 3'd1);
      9'h03B: k = kp(3'd3, 3'd2);  9'h031: k = kp(3'd3, 3'd3);
      9'h043: k = kp(3'd3, 3'd4);  9'h042: k = kp(3'd3, 3'd5);
      9'h03A: k = kp(3'd3, 3'd6);  9'h044: k = kp(3'd3, 3'd7);
      9'h04B: k = kp(3'd4, 3'd0);  9'h041: k = kp(3'd4, 3'd1);
      9'h04D: k = kp(3'd4, 3'd2);  9'h04C: k = kp(3'd4, 3'd3);
      9'h049: k = kp(3'd4, 3'd4);  9'h054: k = kp(3'd4, 3'd5);
      9'h052: k = kp(3'd4, 3'd6);  9'h04A: k = kp(3'd4, 3'd7);
      9'h03E: k = kp(3'd5, 3'd0);  9'h046: k = kp(3'd5, 3'd1);
      9'h045: k = kp(3'd5, 3'd2);  9'h04E: k = kp(3'd5, 3'd3);
      9'h055: k = kp(3'd5, 3'd4);  9'h05B: k = kp(3'd5, 3'd5);
      9'h05D: k = kp(3'd5, 3'd6);  9'h00E: k = kp(3'd5, 3'd7);
      9'h012: k = kp(3'd6, 3'd0);  9'h059: k = kp(3'd6, 3'd0);
      9'h014: k = kp(3'd6, 3'd1);  9'h114: k = kp(3'd6, 3'd1);
      9'h011: k = kp(3'd6, 3'd2);  9'h111: k = kp(3'd6, 3'd2);
      9'h029: k = kp(3'd6, 3'd3);  9'h076: k = kp(3'd6, 3'd4);
      9'h00D: k = kp(3'd6, 3'd5);  9'h058: k = kp(3'd6, 3'd6);
      9'h172: k = kp(3'd6, 3'd7);  9'h16B: k = kp(3'd6, 3'd7);
      9'h174: k = kp(3'd6, 3'd7);
      9'h05A: k = kp(3'd7, 3'd0);  9'h15A: k = kp(3'd7, 3'd0);
      9'h066: k = kp(3'd7, 3'd1);  9'h171: k = kp(3'd7, 3'd1);
      9'h005: k = kp(3'd7, 3'd2);  9'h006: k = kp(3'd7, 3'd3);
      9'h004: k = kp(3'd7, 3'd4);  9'h00C: k = kp(3'd7, 3'd5);
      9'h003: k = kp(3'd7, 3'd6);  9'h00B: k = kp(3'd7, 3'd7);
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: pin synchronizers, clock glitch filter, 11-bit frame FSM and
// inter-edge watchdog. Emits one byte per good frame.
module ps2_rx
  import lm80c_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       sys_clock,
  input  logic       RESET,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] data_byte,
  output logic       frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  logic          r_clk_meta, r_clk_sync, r_dat_meta, r_dat_sync;
  logic          r_clk_filt, r_fall, r_fall_data;
  logic [FW-1:0] r_flt_cnt;

  rx_state_t     r_state, w_state_nxt;
  logic [2:0]    r_bit_cnt, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_par_ok, w_par_nxt;
  logic [WW-1:0] r_wd;
  logic          r_byte_valid, w_bv_nxt;
  logic          r_frame_err, w_err_nxt;
  logic          w_expire;

  // The filtered clock only moves after FILTER_LEN identical samples; r_fall marks
  // the falling transition and captures data in the same cycle.
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      r_clk_meta  <= 1'b1;
      r_clk_sync  <= 1'b1;
      r_dat_meta  <= 1'b1;
      r_dat_sync  <= 1'b1;
      r_clk_filt  <= 1'b1;
      r_flt_cnt   <= '0;
      r_fall      <= 1'b0;
      r_fall_data <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk;
      r_clk_sync <= r_clk_meta;
      r_dat_meta <= ps2_data;
      r_dat_sync <= r_dat_meta;
      r_fall     <= 1'b0;
      if (r_clk_sync == r_clk_filt) begin
        r_flt_cnt <= '0;
      end else if (r_flt_cnt == FLT_LAST) begin
        r_flt_cnt   <= '0;
        r_clk_filt  <= r_clk_sync;
        r_fall      <= ~r_clk_sync;
        r_fall_data <= r_dat_sync;
      end else begin
        r_flt_cnt <= r_flt_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bit_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_par_nxt   = r_par_ok;
    w_bv_nxt    = 1'b0;
    w_err_nxt   = 1'b0;
    w_expire    = (r_state != RX_IDLE) && !r_fall && (r_wd == WD_LAST);
    if (r_fall) begin
      case (r_state)
        RX_IDLE: begin
          if (!r_fall_data) begin
            w_state_nxt = RX_DATA;
            w_bit_nxt   = 3'd0;
          end
        end
        RX_DATA: begin
          w_shift_nxt = {r_fall_data, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) w_state_nxt = RX_PARITY;
          else                   w_bit_nxt   = r_bit_cnt + 1'b1;
        end
        RX_PARITY: begin
          w_par_nxt   = ^{r_shift, r_fall_data};
          w_state_nxt = RX_STOP;
        end
        RX_STOP: begin
          w_state_nxt = RX_IDLE;
          if (r_fall_data && r_par_ok) w_bv_nxt  = 1'b1;
          else                         w_err_nxt = 1'b1;
        end
        default: w_state_nxt = RX_IDLE;
      endcase
    end else if (w_expire) begin
      w_state_nxt = RX_IDLE;
      w_err_nxt   = 1'b1;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      r_state      <= RX_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_ok     <= 1'b0;
      r_wd         <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_bit_nxt;
      r_shift      <= w_shift_nxt;
      r_par_ok     <= w_par_nxt;
      r_byte_valid <= w_bv_nxt;
      r_frame_err  <= w_err_nxt;
      if (r_state == RX_IDLE || r_fall) r_wd <= '0;
      else if (r_wd != WD_LAST)         r_wd <= r_wd + 1'b1;
    end
  end

  assign byte_valid = r_byte_valid;
  assign data_byte  = r_shift;
  assign frame_err  = r_frame_err;

endmodule

// File: rtl/lm80c_ps2_matrix.sv
// PS/2 set-2 keyboard to LM80C 8x8 active-low key matrix. Decodes E0/F0/E1
// prefixes and keeps one bit per key cell; 0 means pressed.
module lm80c_ps2_matrix
  import lm80c_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic            sys_clock,
  input  logic            RESET,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  input  logic            kbd_clear,
  output logic [7:0][7:0] KM,
  output logic            code_valid,
  output logic [7:0]      code,
  output logic            code_ext,
  output logic            code_brk,
  output logic            frame_err
);

  logic            w_byte_valid, w_frame_err;
  logic [7:0]      w_byte;
  key_pos_t        w_pos;

  logic [7:0][7:0] r_km;
  logic            r_code_valid, r_code_ext, r_code_brk;
  logic [7:0]      r_code;
  logic            r_ext, r_brk;
  logic [2:0]      r_skip;

  ps2_rx #(
    .FILTER_LEN(FILTER_LEN),
    .TIMEOUT   (TIMEOUT)
  ) u_rx (
    .sys_clock (sys_clock),
    .RESET     (RESET),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(w_byte_valid),
    .data_byte (w_byte),
    .frame_err (w_frame_err)
  );

  assign w_pos = key_map(r_ext, w_byte);

  // E1 always reloads the skip count, even mid-skip; kbd_clear is applied last so it
  // overrides any matrix write or prefix update from the same cycle.
  always_ff @(posedge sys_clock) begin
    if (RESET) begin
      r_km         <= '1;
      r_code_valid <= 1'b0;
      r_code       <= '0;
      r_code_ext   <= 1'b0;
      r_code_brk   <= 1'b0;
      r_ext        <= 1'b0;
      r_brk        <= 1'b0;
      r_skip       <= '0;
    end else begin
      r_code_valid <= 1'b0;
      if (w_byte_valid) begin
        if (w_byte == PS2_PAUSE) begin
          r_skip <= 3'd7;
          r_ext  <= 1'b0;
          r_brk  <= 1'b0;
        end else if (r_skip != 3'd0) begin
          r_skip <= r_skip - 1'b1;
          r_ext  <= 1'b0;
          r_brk  <= 1'b0;
        end else if (w_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else if (w_byte == PS2_BRK) begin
          r_brk <= 1'b1;
        end else if (is_ignored(w_byte)) begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
        end else begin
          if (w_pos.hit) r_km[w_pos.row][w_pos.col] <= r_brk;
          r_code_valid <= 1'b1;
          r_code       <= w_byte;
          r_code_ext   <= r_ext;
          r_code_brk   <= r_brk;
          r_ext        <= 1'b0;
          r_brk        <= 1'b0;
        end
      end
      if (kbd_clear) begin
        r_km  <= '1;
        r_ext <= 1'b0;
        r_brk <= 1'b0;
      end
    end
  end

  assign KM         = r_km;
  assign code_valid = r_code_valid;
  assign code       = r_code;
  assign code_ext   = r_code_ext;
  assign code_brk   = r_code_brk;
  assign frame_err  = w_frame_err;

endmodule
